// File: rtl/oops_structs.sv
// Shared load/store path types and default sizing for the address buffer.
package oops_structs;

  localparam int unsigned ADDR_BUF_DEPTH  = 15;
  localparam int unsigned ADDR_BUF_ADDR_W = 32;
  localparam int unsigned ADDR_BUF_TAG_W  = 5;

  typedef struct packed {
    logic [ADDR_BUF_ADDR_W-1:0] addr;
    logic [ADDR_BUF_TAG_W-1:0]  tag;
    logic                       is_store;
  } addr_buf_entry_t;

endpackage

// File: rtl/addr_buf_youngest_match.sv
// Finds the matching entry closest to the tail (youngest) in a circular buffer.
module addr_buf_youngest_match #(
  parameter int unsigned DEPTH = 15
) (
  input  logic [DEPTH-1:0]         match_i,
  input  logic [$clog2(DEPTH)-1:0] tail_i,
  output logic                     hit_o,
  output logic [$clog2(DEPTH)-1:0] idx_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);

  int unsigned slot;

  // Walk slots oldest-to-youngest starting at tail; the last hit seen wins.
  always_comb begin
    hit_o = 1'b0;
    idx_o = '0;
    slot  = 0;
    for (int unsigned k = 0; k < DEPTH; k++) begin
      slot = 32'(tail_i) + k;
      if (slot >= DEPTH) slot = slot - DEPTH;
      if (match_i[slot]) begin
        hit_o = 1'b1;
        idx_o = PTR_W'(slot);
      end
    end
  end

endmodule

// File: rtl/addr_buffer_cam.sv
// In-order address buffer with youngest-store associative search, flush and occupancy.
module addr_buffer_cam
  import oops_structs::*;
#(
  parameter int unsigned DEPTH  = ADDR_BUF_DEPTH,
  parameter int unsigned ADDR_W = ADDR_BUF_ADDR_W,
  parameter int unsigned TAG_W  = ADDR_BUF_TAG_W
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         vld_i,
  output logic                         rdy_i,
  input  logic [ADDR_W-1:0]            addr_i,
  input  logic [TAG_W-1:0]             tag_i,
  input  logic                         is_store_i,
  output logic                         vld_o,
  input  logic                         rdy_o,
  output logic [ADDR_W-1:0]            addr_o,
  output logic [TAG_W-1:0]             tag_o,
  output logic                         is_store_o,
  input  logic                         flush_i,
  input  logic                         query_vld_i,
  input  logic [ADDR_W-1:0]            query_addr_i,
  output logic                         hit_o,
  output logic [TAG_W-1:0]             hit_tag_o,
  output logic [$clog2(DEPTH+1)-1:0]   count_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH+1);
  localparam logic [ADDR_W-1:0] WORD_MASK = ~ADDR_W'(3);

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [TAG_W-1:0]  tag;
    logic              is_store;
  } entry_t;

  entry_t            mem_q [DEPTH];
  logic [PTR_W-1:0]  head_q, head_d, tail_q, tail_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              enq, deq;
  logic [DEPTH-1:0]  valid, match;
  logic              any_match;
  logic [PTR_W-1:0]  match_idx;
  int unsigned       offset;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH-1)) ? '0 : p + 1'b1;
  endfunction

  assign rdy_i   = (count_q < CNT_W'(DEPTH));
  assign vld_o   = (count_q != '0);
  assign enq     = vld_i && rdy_i;
  assign deq     = vld_o && rdy_o;
  assign count_o = count_q;

  assign addr_o     = vld_o ? mem_q[head_q].addr     : '0;
  assign tag_o      = vld_o ? mem_q[head_q].tag      : '0;
  assign is_store_o = vld_o ? mem_q[head_q].is_store : 1'b0;

  // Pointer/occupancy update; flush wins over any transfer in the same cycle.
  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (flush_i) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      if (enq) tail_d = ptr_inc(tail_q);
      if (deq) head_d = ptr_inc(head_q);
      case ({enq, deq})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (enq) mem_q[tail_q] <= '{addr: addr_i, tag: tag_i, is_store: is_store_i};
  end

  // Slot i is live when its distance from head is below the occupancy.
  always_comb begin
    valid  = '0;
    match  = '0;
    offset = 0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (i >= 32'(head_q)) offset = i - 32'(head_q);
      else                  offset = i + DEPTH - 32'(head_q);
      valid[i] = (offset < 32'(count_q));
      match[i] = valid[i] && mem_q[i].is_store &&
                 (((mem_q[i].addr ^ query_addr_i) & WORD_MASK) == '0);
    end
  end

  addr_buf_youngest_match #(.DEPTH(DEPTH)) u_youngest (
    .match_i (match),
    .tail_i  (tail_q),
    .hit_o   (any_match),
    .idx_o   (match_idx)
  );

  assign hit_o     = query_vld_i && any_match;
  assign hit_tag_o = hit_o ? mem_q[match_idx].tag : '0;

endmodule

// File: tb/tb_addr_buffer_cam.sv
// Directed bench for addr_buffer_cam: vector table plus queue-model sequences.
module tb_addr_buffer_cam;

  logic        clk, rst;
  logic        vld_i, rdy_i, is_store_i, vld_o, rdy_o, is_store_o;
  logic [31:0] addr_i, addr_o, query_addr_i;
  logic [4:0]  tag_i, tag_o, hit_tag_o;
  logic        flush_i, query_vld_i, hit_o;
  logic [3:0]  count_o;

  int pass_cnt = 0;
  int total_cnt = 0;

  addr_buffer_cam #(.DEPTH(15), .ADDR_W(32), .TAG_W(5)) dut (
    .clk(clk), .rst(rst),
    .vld_i(vld_i), .rdy_i(rdy_i), .addr_i(addr_i), .tag_i(tag_i), .is_store_i(is_store_i),
    .vld_o(vld_o), .rdy_o(rdy_o), .addr_o(addr_o), .tag_o(tag_o), .is_store_o(is_store_o),
    .flush_i(flush_i), .query_vld_i(query_vld_i), .query_addr_i(query_addr_i),
    .hit_o(hit_o), .hit_tag_o(hit_tag_o), .count_o(count_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    logic [4:0]  tag;
    logic        st;
  } ment_t;

  ment_t q[$];

  typedef struct {
    logic        vld;
    logic [31:0] addr;
    logic [4:0]  tag;
    logic        st;
    logic        rdy;
    logic        qv;
    logic [31:0] qaddr;
    logic        e_vld;
    logic        e_rdy;
    logic [31:0] e_addr;
    logic [4:0]  e_tag;
    logic        e_st;
    logic [3:0]  e_cnt;
    logic        e_hit;
    logic [4:0]  e_htag;
  } vec_t;

  vec_t vt[11];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total_cnt++;
    if (act !== exp) $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    else pass_cnt++;
  endtask

  task automatic drive(input logic v, input logic [31:0] a, input logic [4:0] t, input logic s,
                       input logic r, input logic f, input logic qv, input logic [31:0] qa);
    vld_i = v; addr_i = a; tag_i = t; is_store_i = s;
    rdy_o = r; flush_i = f; query_vld_i = qv; query_addr_i = qa;
  endtask

  // One clock: check outputs against the queue model, then advance the model on the edge.
  task automatic cycle(input logic v, input logic [31:0] a, input logic [4:0] t, input logic s,
                       input logic r, input logic f, input logic qv, input logic [31:0] qa);
    ment_t e;
    logic  exp_vld, exp_rdy, en, de, mh;
    logic [4:0] mt;
    drive(v, a, t, s, r, f, qv, qa);
    #1;
    exp_rdy = (q.size() < 15);
    exp_vld = (q.size() != 0);
    chk("rdy_i", 64'(rdy_i), 64'(exp_rdy));
    chk("vld_o", 64'(vld_o), 64'(exp_vld));
    chk("count_o", 64'(count_o), 64'(q.size()));
    if (exp_vld) begin
      chk("addr_o", 64'(addr_o), 64'(q[0].addr));
      chk("tag_o", 64'(tag_o), 64'(q[0].tag));
      chk("is_store_o", 64'(is_store_o), 64'(q[0].st));
    end else begin
      chk("addr_o_empty", 64'(addr_o), 64'(0));
      chk("tag_o_empty", 64'(tag_o), 64'(0));
    end
    mh = 1'b0; mt = '0;
    if (qv) begin
      for (int i = q.size() - 1; i >= 0; i--) begin
        if (!mh && q[i].st && (q[i].addr[31:2] == qa[31:2])) begin
          mh = 1'b1; mt = q[i].tag;
        end
      end
    end
    chk("hit_o", 64'(hit_o), 64'(mh));
    chk("hit_tag_o", 64'(hit_tag_o), 64'(mt));
    en = v && exp_rdy;
    de = exp_vld && r;
    e.addr = a; e.tag = t; e.st = s;
    @(posedge clk);
    #1;
    if (f) q.delete();
    else begin
      if (de) void'(q.pop_front());
      if (en) q.push_back(e);
    end
  endtask

  initial begin
    vt[0]  = '{0, 32'h000, 0, 0, 0, 0, 32'h000,  0, 1, 32'h000, 0, 0, 0, 0, 0};
    vt[1]  = '{1, 32'h200, 3, 1, 0, 1, 32'h200,  0, 1, 32'h000, 0, 0, 0, 0, 0};
    vt[2]  = '{1, 32'h200, 4, 0, 0, 1, 32'h200,  1, 1, 32'h200, 3, 1, 1, 1, 3};
    vt[3]  = '{1, 32'h202, 7, 1, 0, 1, 32'h203,  1, 1, 32'h200, 3, 1, 2, 1, 3};
    vt[4]  = '{0, 32'h000, 0, 0, 0, 1, 32'h200,  1, 1, 32'h200, 3, 1, 3, 1, 7};
    vt[5]  = '{0, 32'h000, 0, 0, 0, 1, 32'h204,  1, 1, 32'h200, 3, 1, 3, 0, 0};
    vt[6]  = '{0, 32'h000, 0, 0, 0, 0, 32'h203,  1, 1, 32'h200, 3, 1, 3, 0, 0};
    vt[7]  = '{0, 32'h000, 0, 0, 1, 1, 32'h200,  1, 1, 32'h200, 3, 1, 3, 1, 7};
    vt[8]  = '{0, 32'h000, 0, 0, 1, 1, 32'h200,  1, 1, 32'h200, 4, 0, 2, 1, 7};
    vt[9]  = '{0, 32'h000, 0, 0, 1, 1, 32'h200,  1, 1, 32'h202, 7, 1, 1, 1, 7};
    vt[10] = '{0, 32'h000, 0, 0, 0, 1, 32'h200,  0, 1, 32'h000, 0, 0, 0, 0, 0};

    rst = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    #12;
    chk("reset_vld_o", 64'(vld_o), 64'(0));
    chk("reset_rdy_i", 64'(rdy_i), 64'(1));
    chk("reset_count_o", 64'(count_o), 64'(0));
    chk("reset_hit_o", 64'(hit_o), 64'(0));
    chk("reset_addr_o", 64'(addr_o), 64'(0));
    @(posedge clk);
    #2 rst = 1'b1;

    // Youngest-match vectors: outputs seen with the row's inputs, before its edge.
    for (int i = 0; i < 11; i++) begin
      drive(vt[i].vld, vt[i].addr, vt[i].tag, vt[i].st, vt[i].rdy, 1'b0, vt[i].qv, vt[i].qaddr);
      #1;
      chk($sformatf("vec%0d_vld_o", i), 64'(vld_o), 64'(vt[i].e_vld));
      chk($sformatf("vec%0d_rdy_i", i), 64'(rdy_i), 64'(vt[i].e_rdy));
      chk($sformatf("vec%0d_addr_o", i), 64'(addr_o), 64'(vt[i].e_addr));
      chk($sformatf("vec%0d_tag_o", i), 64'(tag_o), 64'(vt[i].e_tag));
      chk($sformatf("vec%0d_is_store_o", i), 64'(is_store_o), 64'(vt[i].e_st));
      chk($sformatf("vec%0d_count_o", i), 64'(count_o), 64'(vt[i].e_cnt));
      chk($sformatf("vec%0d_hit_o", i), 64'(hit_o), 64'(vt[i].e_hit));
      chk($sformatf("vec%0d_hit_tag_o", i), 64'(hit_tag_o), 64'(vt[i].e_htag));
      @(posedge clk);
      #1;
    end

    // Fill to full then drain in order.
    for (int i = 0; i < 15; i++) cycle(1, 32'h100 + 32'(4*i), 5'(i), 0, 0, 0, 0, 0);
    cycle(0, 0, 0, 0, 0, 0, 0, 0);
    chk("full_rdy_i", 64'(rdy_i), 64'(0));
    chk("full_count_o", 64'(count_o), 64'(15));
    for (int i = 0; i < 15; i++) begin
      chk("drain_order", 64'(addr_o), 64'(32'h100 + 32'(4*i)));
      cycle(0, 0, 0, 0, 1, 0, 0, 0);
    end
    cycle(0, 0, 0, 0, 0, 0, 0, 0);

    // Wrap: push 10, pop 10, push 15 across slot 14 -> 0.
    for (int i = 0; i < 10; i++) cycle(1, 32'h300 + 32'(4*i), 5'(i), 0, 0, 0, 0, 0);
    for (int i = 0; i < 10; i++) cycle(0, 0, 0, 0, 1, 0, 0, 0);
    for (int i = 0; i < 15; i++) cycle(1, 32'h400 + 32'(4*i), 5'(i), 0, 0, 0, 0, 0);
    chk("wrap_count_o", 64'(count_o), 64'(15));
    for (int i = 0; i < 10; i++) cycle(0, 0, 0, 0, 1, 0, 0, 0);

    // Steady-state enqueue+dequeue at count 5.
    for (int i = 0; i < 20; i++) begin
      cycle(1, 32'h600 + 32'(4*i), 5'(i), 0, 1, 0, 0, 0);
      chk("steady_count_o", 64'(count_o), 64'(5));
    end

    // Refill with stores, then push+pop at full: only the pop happens.
    for (int i = 0; i < 10; i++) cycle(1, 32'h700 + 32'(4*i), 5'(i + 10), 1, 0, 0, 1, 32'h700);
    cycle(1, 32'h800, 5'd31, 1, 1, 0, 1, 32'h724);
    chk("full_pushpop_count_o", 64'(count_o), 64'(14));
    for (int i = 0; i < 6; i++) cycle(0, 0, 0, 0, 1, 0, 1, 32'h724);

    // Flush with concurrent traffic and a hitting query.
    chk("preflush_count_o", 64'(count_o), 64'(8));
    cycle(1, 32'h724, 5'd30, 1, 1, 1, 1, 32'h724);
    cycle(0, 0, 0, 0, 0, 0, 1, 32'h724);
    chk("postflush_hit_o", 64'(hit_o), 64'(0));

    // Asynchronous reset between edges.
    for (int i = 0; i < 6; i++) cycle(1, 32'h900 + 32'(4*i), 5'(i), 1, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 0, 1, 32'h900);
    #2 rst = 1'b0;
    #1;
    chk("arst_vld_o", 64'(vld_o), 64'(0));
    chk("arst_rdy_i", 64'(rdy_i), 64'(1));
    chk("arst_count_o", 64'(count_o), 64'(0));
    chk("arst_addr_o", 64'(addr_o), 64'(0));
    chk("arst_hit_o", 64'(hit_o), 64'(0));
    q.delete();
    @(posedge clk);
    #2 rst = 1'b1;
    cycle(1, 32'hA00, 5'd9, 1, 0, 0, 0, 0);
    cycle(0, 0, 0, 0, 0, 0, 1, 32'hA00);
    chk("arst_enq_addr_o", 64'(addr_o), 64'(32'hA00));

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/addr_buffer_cam.md
Name: addr_buffer_cam

Overview:
Parametrised in-order address buffer for the load/store path, successor to the fixed-width address buffer queue. It holds address entries (address, ROB tag, store flag) between address generation and the memory stage. It adds an associative search port that reports the youngest buffered store matching a query word address, used for load/store disambiguation. It also adds a global flush and an occupancy count, and supports any depth, including non-power-of-two.

Parameters:
DEPTH, 15, number of entries; any value >= 2
ADDR_W, 32, address width in bits
TAG_W, 5, ROB tag width in bits

Ports:
clk  input  1  clock; all state updates on rising edge
rst  input  1  asynchronous reset, active-low
vld_i  input  1  enqueue valid
rdy_i  output  1  enqueue ready
addr_i  input  ADDR_W  enqueue address
tag_i  input  TAG_W  enqueue ROB tag
is_store_i  input  1  enqueue entry is a store
vld_o  output  1  head entry valid
rdy_o  input  1  consumer accepts head
addr_o  output  ADDR_W  head address
tag_o  output  TAG_W  head tag
is_store_o  output  1  head store flag
flush_i  input  1  synchronous squash of all entries
query_vld_i  input  1  search request
query_addr_i  input  ADDR_W  search address
hit_o  output  1  a matching store exists
hit_tag_o  output  TAG_W  tag of the youngest matching store
count_o  output  $clog2(DEPTH+1)  current occupancy

Behaviour:
- Reset (rst low, asynchronous): head, tail and count are cleared to 0; vld_o=0, rdy_i=1, count_o=0, hit_o=0, hit_tag_o=0, addr_o/tag_o/is_store_o=0. Entry storage is not reset.
- Enqueue fires on vld_i && rdy_i. rdy_i = (count < DEPTH), registered-state only, with no combinational path from rdy_o. A full buffer refuses enqueue even if a dequeue occurs in the same cycle.
- Dequeue fires on vld_o && rdy_o. vld_o = (count != 0). Head fields are driven from storage and forced to 0 when empty.
- Latency: an entry enqueued at edge N is visible on the head outputs from cycle N+1. There is no bypass.
- Simultaneous enqueue and dequeue with count in [1, DEPTH-1]: count is unchanged and both pointers advance.
- Pointers wrap from DEPTH-1 to 0 with explicit compare, not power-of-two masking.
- flush_i (sampled on the edge) sets count=0 and head=tail=0. It overrides any enqueue or dequeue in the same cycle; those transfers are lost, and the producer must not treat them as accepted. rdy_i=1 in the following cycle.
- Search is combinational on the current registered state.
  - Match condition: entry is valid, is_store=1, and addr[ADDR_W-1:2] == query_addr_i[ADDR_W-1:2].
  - hit_o = query_vld_i && any match.
  - hit_tag_o = tag of the youngest match (closest to tail, scanning backwards from tail-1); it is 0 when there is no hit.
  - The head entry being dequeued this cycle still participates. An entry being enqueued this cycle does not.
  - Search does not depend on flush_i in the same cycle.
- count_o always equals the number of valid entries. Its width holds DEPTH exactly.

Decomposition:
- Shared package (oops_structs) holds:
  - addr_buf_entry_t: addr, tag, is_store, sized by ADDR_BUF_ADDR_W and ADDR_BUF_TAG_W constants.
  - ADDR_BUF_DEPTH default constant.
- The youngest-match search is a natural sub-module, addr_buf_youngest_match.
  - Inputs: per-entry match vector, tail pointer, DEPTH.
  - Outputs: hit and matched index.
  - It rotates the vector by tail and applies a priority find-last.

Test Plan:
- Reset then fill: enqueue 15 entries with addr 0x100+4i -> rdy_i=0 after the 15th, count_o=15. Dequeue all -> addresses in order 0x100..0x138, then vld_o=0, head fields 0.
- Wrap with DEPTH=15: push 10, pop 10, push 15 -> count_o=15, and pops return the pushed order across the index 14->0 wrap.
- Youngest match: push store 0x200 tag 3, load 0x200 tag 4, store 0x202 tag 7; query 0x200 -> hit_o=1, hit_tag_o=7. Query 0x204 -> hit_o=0, hit_tag_o=0.
- Simultaneous enqueue/dequeue at count 5 for 20 cycles -> count_o stays 5 and order is preserved. At full, vld_i=1 and rdy_o=1 -> only a dequeue occurs and count_o=14.
- Flush with concurrent traffic: count 8, flush_i=1 with vld_i=1 and rdy_o=1 -> next cycle count_o=0, vld_o=0, rdy_i=1, and the query reports no hit.
- Asynchronous reset mid-stream: assert rst low between edges with count 6 -> outputs return to their reset values immediately, without a clock edge. Enqueue after deassert -> the entry appears on the head one cycle later.
